// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two per-source result FIFOs, round-robin pop into a registered CDB broadcast.
// Optional same-cycle bypass of an empty FIFO is enabled by defining CDB_ARB_BYPASS_EN.
module cdb_arbiter #(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear_flag_in,
  input  logic              alu_result_enable_in,
  input  logic [IDX_W-1:0]  alu_result_idx_in,
  input  logic [DATA_W-1:0] alu_result_value_in,
  input  logic              lb_result_enable_in,
  input  logic [IDX_W-1:0]  lb_result_idx_in,
  input  logic [DATA_W-1:0] lb_result_value_in,
  output logic              alu_full_out,
  output logic              lb_full_out,
  output logic              cdb_enable_out,
  output logic [IDX_W-1:0]  cdb_idx_out,
  output logic [DATA_W-1:0] cdb_value_out,
  output logic              cdb_src_out,
  output logic              overflow_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LB  = 1'b1
  } src_e;

  logic              active;
  logic [1:0]        in_en;
  logic [IDX_W-1:0]  in_idx   [2];
  logic [DATA_W-1:0] in_val   [2];
  logic [IDX_W-1:0]  head_idx [2];
  logic [DATA_W-1:0] head_val [2];
  logic [1:0]        nonempty;
  logic [1:0]        push_req;
  logic [1:0]        at_cap;
  logic [1:0]        full;
  logic [1:0]        cand;
  logic [1:0]        rd;
  logic [1:0]        wr;
  logic [1:0]        byp;
  logic              any;
  src_e              win;
  src_e              prio;
  logic [IDX_W-1:0]  win_idx;
  logic [DATA_W-1:0] win_val;

  assign active    = rdy & ~clear_flag_in;
  assign in_en     = {lb_result_enable_in, alu_result_enable_in};
  assign in_idx[0] = alu_result_idx_in;
  assign in_idx[1] = lb_result_idx_in;
  assign in_val[0] = alu_result_value_in;
  assign in_val[1] = lb_result_value_in;

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [IDX_W-1:0]  idx_mem [DEPTH];
    logic [DATA_W-1:0] val_mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    always_ff @(posedge clk) begin
      if (wr[g]) begin
        idx_mem[tail] <= in_idx[g];
        val_mem[tail] <= in_val[g];
      end
    end

    always_ff @(posedge clk) begin
      if (rst || clear_flag_in) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else if (rdy) begin
        if (wr[g]) tail <= tail + 1'b1;
        if (rd[g]) head <= head + 1'b1;
        if (wr[g] && !rd[g])
          count <= count + 1'b1;
        else if (!wr[g] && rd[g])
          count <= count - 1'b1;
      end
    end

    assign nonempty[g] = (count != '0);
    assign push_req[g] = in_en[g] & active;
    assign at_cap[g]   = (count == CNT_W'(DEPTH));
    assign full[g]     = (count >= CNT_W'(DEPTH - 1));
    assign head_idx[g] = idx_mem[head];
    assign head_val[g] = val_mem[head];
  end

`ifdef CDB_ARB_BYPASS_EN
  // An arriving result competes immediately when its FIFO has nothing older queued.
  assign cand = nonempty | (push_req & ~nonempty);
`else
  assign cand = nonempty;
`endif

  always_comb begin
    any     = 1'b0;
    win     = SRC_ALU;
    rd      = '0;
    byp     = '0;
    win_idx = '0;
    win_val = '0;
    if (active && (cand != '0)) begin
      any = 1'b1;
      if (&cand)
        win = prio;
      else if (cand[0])
        win = SRC_ALU;
      else
        win = SRC_LB;
      rd[win]  = nonempty[win];
      byp[win] = ~nonempty[win];
      win_idx  = nonempty[win] ? head_idx[win] : in_idx[win];
      win_val  = nonempty[win] ? head_val[win] : in_val[win];
    end
    // A bypassed result is consumed by the CDB and must not also enter the FIFO.
    wr = push_req & ~at_cap & ~byp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_enable_out <= 1'b0;
      cdb_idx_out    <= '0;
      cdb_value_out  <= '0;
      cdb_src_out    <= 1'b0;
      overflow_out   <= 1'b0;
      prio           <= SRC_ALU;
    end else begin
      cdb_enable_out <= any;
      if (|(push_req & at_cap))
        overflow_out <= 1'b1;
      if (any) begin
        cdb_idx_out   <= win_idx;
        cdb_value_out <= win_val;
        cdb_src_out   <= win;
        if (&cand)
          prio <= (win == SRC_ALU) ? SRC_LB : SRC_ALU;
      end
    end
  end

  assign alu_full_out = full[0];
  assign lb_full_out  = full[1];

endmodule
